avalon_reg_slave: RTL and testbench



---
 rtl/avalon_reg_pkg.sv | 42 ++++
 rtl/avalon_reg_slave_if.sv | 42 ++++
 rtl/avalon_reg_slave_irq_ctrl.sv | 71 +++++++
 rtl/avalon_reg_slave.sv | 198 +++++++++++++++++++
 tb/tb_avalon_reg_slave.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_reg_pkg.sv
// ---------------------------------------------------------------------------
// avalon_reg_pkg
// Shared definitions for the Avalon-MM register slave:
//   - word offsets of the register map (byte offset >> 2, decoded on address[4:2])
//   - ERR_PATTERN returned for unmapped accesses and protocol errors
//   - access FSM state type
//   - be_merge: byte-lane merge used by every byte-enabled register write
// ---------------------------------------------------------------------------
package avalon_reg_pkg;

    localparam logic [2:0] REG_ID      = 3'd0;  // 0x00
    localparam logic [2:0] REG_SCRATCH = 3'd1;  // 0x04
    localparam logic [2:0] REG_CTRL    = 3'd2;  // 0x08
    localparam logic [2:0] REG_STATUS  = 3'd3;  // 0x0C
    localparam logic [2:0] REG_PENDING = 3'd4;  // 0x10
    localparam logic [2:0] REG_MASK    = 3'd5;  // 0x14
    localparam logic [2:0] REG_ERR     = 3'd6;  // 0x18
    localparam logic [2:0] REG_HOLE    = 3'd7;  // 0x1C, treated as unmapped

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_RELEASE
    } state_t;

    // Replace the byte lanes of old_value selected by be with new_value.
    function automatic logic [31:0] be_merge(input logic [31:0] old_value,
                                             input logic [31:0] new_value,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_value;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_value[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/avalon_reg_slave_if.sv
// ---------------------------------------------------------------------------
// avalon_reg_slave_if
// Avalon-MM request/response bundle between the SPI bridge (master) and the
// register slave.
//   avalon_read / avalon_write : request strobes, held until acknowledge
//   address                    : byte address
//   byte_enable                : write byte lanes
//   write_data                 : write data
//   read_data                  : read data, valid in the acknowledge cycle
//   acknowledge                : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface avalon_reg_slave_if;

    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        acknowledge;

    modport master (
        output avalon_read,
        output avalon_write,
        output address,
        output byte_enable,
        output write_data,
        input  read_data,
        input  acknowledge
    );

    modport slave (
        input  avalon_read,
        input  avalon_write,
        input  address,
        input  byte_enable,
        input  write_data,
        output read_data,
        output acknowledge
    );

endinterface

// File: rtl/avalon_reg_slave_irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
// Interrupt block of the register slave: rising-edge detection on irq_src,
// IRQ_PENDING (write-one-to-clear) and IRQ_MASK storage, registered interrupt.
// Ports:
//   clk, nreset  : clock, asynchronous active-low reset
//   irq_src      : interrupt sources, rising-edge sensitive
//   w1c_en       : a write to IRQ_PENDING is performed this cycle
//   w1c_bits     : bits to clear (write data already gated by byte enables)
//   mask_we      : a write to IRQ_MASK is performed this cycle
//   mask_wdata   : new mask value (already byte-lane merged)
//   pending,mask : current register contents
//   interrupt    : registered OR of pending & mask
// ---------------------------------------------------------------------------
module irq_ctrl
    import avalon_reg_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             w1c_en,
    input  logic [N_IRQ-1:0] w1c_bits,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic             interrupt
);

    logic [N_IRQ-1:0] src_reg;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pending_reg;
    logic [N_IRQ-1:0] pending_next;
    logic [N_IRQ-1:0] mask_reg;
    logic [N_IRQ-1:0] mask_next;
    logic             interrupt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_bit
            assign rise[gi] = irq_src[gi] & ~src_reg[gi];
            // A new edge beats a simultaneous clear so no event is lost.
            assign pending_next[gi] = rise[gi]                  ? 1'b1 :
                                      (w1c_en & w1c_bits[gi])   ? 1'b0 :
                                      pending_reg[gi];
        end
    endgenerate

    assign mask_next = mask_we ? mask_wdata : mask_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            src_reg       <= '0;
            pending_reg   <= '0;
            mask_reg      <= '0;
            interrupt_reg <= 1'b0;
        end else begin
            src_reg       <= irq_src;
            pending_reg   <= pending_next;
            mask_reg      <= mask_next;
            interrupt_reg <= |(pending_reg & mask_reg);
        end
    end

    assign pending   = pending_reg;
    assign mask      = mask_reg;
    assign interrupt = interrupt_reg;

endmodule

// File: rtl/avalon_reg_slave.sv
// ---------------------------------------------------------------------------
// avalon_reg_slave
// Avalon-MM register slave for the 32-bit bus of the SPI-to-Avalon bridge.
// Each request is decoded in IDLE, acknowledged for one cycle in ACK, and the
// FSM then waits in RELEASE until the master drops its strobes, so a held
// strobe produces exactly one access.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   bus         : avalon_reg_slave_if.slave (strobes, address, data, ack)
//   status_in   : live status word, returned by STATUS
//   irq_src     : interrupt sources, rising-edge sensitive
//   ctrl_out    : CTRL register contents
//   interrupt   : registered OR of IRQ_PENDING & IRQ_MASK
// ---------------------------------------------------------------------------
module avalon_reg_slave
    import avalon_reg_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'h1D60_0001,
    parameter int          N_IRQ      = 8,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                nreset,
    avalon_reg_slave_if.slave   bus,
    input  logic [31:0]         status_in,
    input  logic [N_IRQ-1:0]    irq_src,
    output logic [31:0]         ctrl_out,
    output logic                interrupt
);

    state_t      state_reg;
    state_t      state_next;
    logic        ack;

    logic        access_valid;
    logic        mapped;
    logic        proto_err;
    logic        is_error;
    logic        wr_hit;
    logic        rd_hit;
    logic [2:0]  word;

    logic [31:0] scratch_reg;
    logic [31:0] scratch_next;
    logic [31:0] ctrl_reg;
    logic [31:0] ctrl_next;
    logic [15:0] err_reg;
    logic [15:0] err_next;
    logic [31:0] read_data_reg;
    logic [31:0] read_data_next;
    logic [31:0] read_mux;

    logic             w1c_en;
    logic [31:0]      w1c_word;
    logic             mask_we;
    logic [31:0]      mask_merged;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [31:0]      pending_word;
    logic [31:0]      mask_word;

    // ---------------- access FSM ----------------
    always_comb begin
        state_next = state_reg;
        ack        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.avalon_read || bus.avalon_write) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                ack        = 1'b1;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus.avalon_read && !bus.avalon_write) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- decode ----------------
    assign word         = bus.address[4:2];
    assign access_valid = (state_reg == ST_IDLE) && (bus.avalon_read || bus.avalon_write);
    assign mapped       = (bus.address[31:5] == '0) && (bus.address[1:0] == 2'b00)
                          && (word != REG_HOLE);
    assign proto_err    = bus.avalon_read && bus.avalon_write;
    assign is_error     = access_valid && (proto_err || !mapped);
    // Only a clean, mapped write may modify state.
    assign wr_hit       = access_valid && bus.avalon_write && !bus.avalon_read && mapped;
    assign rd_hit       = access_valid && bus.avalon_read;

    // ---------------- read mux ----------------
    always_comb begin
        read_mux = ERR_PATTERN;
        case (word)
            REG_ID:      read_mux = ID_VALUE;
            REG_SCRATCH: read_mux = scratch_reg;
            REG_CTRL:    read_mux = ctrl_reg;
            REG_STATUS:  read_mux = status_in;
            REG_PENDING: read_mux = pending_word;
            REG_MASK:    read_mux = mask_word;
            REG_ERR:     read_mux = {16'h0000, err_reg};
            default:     read_mux = ERR_PATTERN;
        endcase
    end

    // ---------------- register next-state ----------------
    always_comb begin
        scratch_next   = scratch_reg;
        ctrl_next      = ctrl_reg;
        err_next       = err_reg;
        read_data_next = read_data_reg;

        if (wr_hit) begin
            case (word)
                REG_SCRATCH: scratch_next = be_merge(scratch_reg, bus.write_data, bus.byte_enable);
                REG_CTRL:    ctrl_next    = be_merge(ctrl_reg, bus.write_data, bus.byte_enable);
                REG_ERR: begin
                    // An empty byte-enable write changes nothing, including the counter.
                    if (|bus.byte_enable) begin
                        err_next = '0;
                    end
                end
                default: ;
            endcase
        end

        // An error access never writes, so it cannot collide with a clear.
        if (is_error && (err_reg != 16'hFFFF)) begin
            err_next = err_reg + 16'd1;
        end

        if (rd_hit) begin
            read_data_next = (proto_err || !mapped) ? ERR_PATTERN : read_mux;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg     <= ST_IDLE;
            scratch_reg   <= '0;
            ctrl_reg      <= CTRL_RESET;
            err_reg       <= '0;
            read_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            scratch_reg   <= scratch_next;
            ctrl_reg      <= ctrl_next;
            err_reg       <= err_next;
            read_data_reg <= read_data_next;
        end
    end

    // ---------------- interrupt block ----------------
    assign w1c_en      = wr_hit && (word == REG_PENDING);
    assign w1c_word    = be_merge(32'h0000_0000, bus.write_data, bus.byte_enable);
    assign mask_we     = wr_hit && (word == REG_MASK);
    assign mask_merged = be_merge(mask_word, bus.write_data, bus.byte_enable);

    irq_ctrl #(
        .N_IRQ (N_IRQ)
    ) u_irq_ctrl (
        .clk        (clk),
        .nreset     (nreset),
        .irq_src    (irq_src),
        .w1c_en     (w1c_en),
        .w1c_bits   (w1c_word[N_IRQ-1:0]),
        .mask_we    (mask_we),
        .mask_wdata (mask_merged[N_IRQ-1:0]),
        .pending    (pending),
        .mask       (mask),
        .interrupt  (interrupt)
    );

    // Zero-extend the N_IRQ-wide interrupt registers to the 32-bit bus.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ext
            if (gi < N_IRQ) begin : g_live
                assign pending_word[gi] = pending[gi];
                assign mask_word[gi]    = mask[gi];
            end else begin : g_pad
                assign pending_word[gi] = 1'b0;
                assign mask_word[gi]    = 1'b0;
            end
        end
    endgenerate

    // ---------------- outputs ----------------
    assign ctrl_out        = ctrl_reg;
    assign bus.read_data   = read_data_reg;
    assign bus.acknowledge = ack;

endmodule

// File: tb/tb_avalon_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_avalon_reg_slave
// Self-checking bench for avalon_reg_slave: a table of register accesses with
// expected read data and ctrl_out, a scoreboard queue of expected read_data
// popped at each acknowledge, and hand-written sequences for held strobes,
// the interrupt path and reset in the ACK cycle.
// ---------------------------------------------------------------------------
module tb_avalon_reg_slave;
    import avalon_reg_pkg::*;

    localparam logic [31:0] ID = 32'h1D60_0001;
    localparam int          NV = 25;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] status_in;
    logic [7:0]  irq_src;
    logic [31:0] ctrl_out;
    logic        interrupt;

    avalon_reg_slave_if bus();

    avalon_reg_slave #(
        .ID_VALUE   (ID),
        .N_IRQ      (8),
        .CTRL_RESET (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .status_in (status_in),
        .irq_src   (irq_src),
        .ctrl_out  (ctrl_out),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd_q[$];
    logic [31:0] last_read;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] status;
        logic [31:0] exp_rd;
        logic [31:0] exp_ctrl;
    } vec_t;

    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus access; irq_drive is applied to irq_src together with the strobes.
    task automatic access_irq(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] rd_expect, input logic [7:0] irq_drive);
        int          waited;
        logic [31:0] exp;
        @(negedge clk);
        bus.avalon_read  = rd;
        bus.avalon_write = wr;
        bus.address      = addr;
        bus.byte_enable  = be;
        bus.write_data   = wdata;
        irq_src          = irq_drive;
        // read_data holds its value across writes
        if (rd) last_read = rd_expect;
        rd_q.push_back(last_read);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.acknowledge && waited < 8);
        exp = rd_q.pop_front();
        if (!bus.acknowledge) begin
            check("ack_timeout", 32'(bus.acknowledge), 32'd1);
        end else begin
            check("ack_latency", 32'(waited), 32'd1);
            check("read_data", bus.read_data, exp);
        end
        $display("txn rd=%0d wr=%0d addr=%h be=%b wdata=%h read_data=%h ctrl_out=%h",
                 rd, wr, addr, be, wdata, bus.read_data, ctrl_out);
        bus.avalon_read  = 1'b0;
        bus.avalon_write = 1'b0;
        @(negedge clk);
        check("ack_width", 32'(bus.acknowledge), 32'd0);
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rd_expect);
        access_irq(rd, wr, addr, be, wdata, rd_expect, irq_src);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int n;

        //           rd    wr    addr          be       wdata          status         exp_rd         exp_ctrl
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 4'hF,    32'h0,         32'h0,         ID,            32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_000C, 4'hF,    32'h0,         32'h1234_5678, 32'h1234_5678, 32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0004, 4'hF,    32'h0,         32'h0,         32'h0,         32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0008, 4'b0101, 32'hAABB_CCDD, 32'h0,         32'h0,         32'h00BB_00DD};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0008, 4'hF,    32'h0,         32'h0,         32'h00BB_00DD, 32'h00BB_00DD};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0040, 4'hF,    32'h0,         32'h0,         ERR_PATTERN,   32'h00BB_00DD};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0004, 4'hF,    32'hFFFF_FFFF, 32'h0,         ERR_PATTERN,   32'h00BB_00DD};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0004, 4'hF,    32'h0,         32'h0,         32'h0,         32'h00BB_00DD};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0018, 4'hF,    32'h0,         32'h0,         32'h2,         32'h00BB_00DD};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0018, 4'hF,    32'h0,         32'h0,         32'h0,         32'h00BB_00DD};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0018, 4'hF,    32'h0,         32'h0,         32'h0,         32'h00BB_00DD};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0004, 4'h0,    32'h1122_3344, 32'h0,         32'h0,         32'h00BB_00DD};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0004, 4'hF,    32'h0,         32'h0,         32'h0,         32'h00BB_00DD};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0004, 4'hF,    32'hCAFE_F00D, 32'h0,         32'h0,         32'h00BB_00DD};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0004, 4'hF,    32'h0,         32'h0,         32'hCAFE_F00D, 32'h00BB_00DD};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_001C, 4'hF,    32'h0,         32'h0,         ERR_PATTERN,   32'h00BB_00DD};
        vecs[16] = '{1'b1, 1'b0, 32'h0000_0006, 4'hF,    32'h0,         32'h0,         ERR_PATTERN,   32'h00BB_00DD};
        vecs[17] = '{1'b0, 1'b1, 32'h0000_001C, 4'hF,    32'h0,         32'h0,         32'h0,         32'h00BB_00DD};
        vecs[18] = '{1'b0, 1'b1, 32'h0000_0104, 4'hF,    32'h1234_5678, 32'h0,         32'h0,         32'h00BB_00DD};
        vecs[19] = '{1'b1, 1'b0, 32'h0000_0004, 4'hF,    32'h0,         32'h0,         32'hCAFE_F00D, 32'h00BB_00DD};
        vecs[20] = '{1'b1, 1'b0, 32'h0000_0018, 4'hF,    32'h0,         32'h0,         32'h4,         32'h00BB_00DD};
        vecs[21] = '{1'b1, 1'b0, 32'h0000_000C, 4'hF,    32'h0,         32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h00BB_00DD};
        vecs[22] = '{1'b0, 1'b1, 32'h0000_0008, 4'b1000, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFBB_00DD};
        vecs[23] = '{1'b1, 1'b0, 32'h0000_0010, 4'hF,    32'h0,         32'h0,         32'h0,         32'hFFBB_00DD};
        vecs[24] = '{1'b1, 1'b0, 32'h0000_0014, 4'hF,    32'h0,         32'h0,         32'h0,         32'hFFBB_00DD};

        // ---------------- reset ----------------
        nreset           = 1'b0;
        bus.avalon_read  = 1'b0;
        bus.avalon_write = 1'b0;
        bus.address      = '0;
        bus.byte_enable  = '0;
        bus.write_data   = '0;
        status_in        = '0;
        irq_src          = '0;
        last_read        = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus.acknowledge), 32'd0);
        check("rst_read_data", bus.read_data, 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_ctrl_out", ctrl_out, 32'h0);
        nreset = 1'b1;
        @(negedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            status_in = vecs[i].status;
            acc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp_rd);
            check($sformatf("ctrl_out_v%0d", i), ctrl_out, vecs[i].exp_ctrl);
        end

        // ---------------- write held for 10 cycles ----------------
        acc(1'b0, 1'b1, 32'h18, 4'hF, 32'h0, 32'h0);   // clear ERR_COUNT
        @(negedge clk);
        bus.avalon_write = 1'b1;
        bus.address      = 32'h40;
        bus.byte_enable  = 4'hF;
        bus.write_data   = 32'h0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.acknowledge) acks++;
        end
        bus.avalon_write = 1'b0;
        check("held_write_acks", 32'(acks), 32'd1);
        acc(1'b1, 1'b0, 32'h18, 4'hF, 32'h0, 32'h1);    // exactly one error counted

        // ---------------- interrupt path ----------------
        acc(1'b0, 1'b1, 32'h14, 4'hF, 32'h0000_0001, 32'h1);
        acc(1'b1, 1'b0, 32'h14, 4'hF, 32'h0, 32'h0000_0001);
        @(negedge clk);
        irq_src = 8'h01;
        n = 0;
        while (!interrupt && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("irq_latency", 32'(interrupt), 32'd1);
        irq_src = 8'h00;
        @(negedge clk);
        irq_src = 8'h02;                                 // masked source
        @(negedge clk);
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        check("irq_masked_hold", 32'(interrupt), 32'd1);
        acc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 32'h0000_0003);
        // W1C of bit 0 in the same cycle as a new bit-0 edge: set wins
        access_irq(1'b0, 1'b1, 32'h10, 4'hF, 32'h0000_0001, 32'h0, 8'h01);
        check("irq_set_wins_int", 32'(interrupt), 32'd1);
        acc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 32'h0000_0003);
        // W1C with no byte lanes clears nothing
        access_irq(1'b0, 1'b1, 32'h10, 4'h0, 32'h0000_0003, 32'h0, 8'h00);
        acc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 32'h0000_0003);
        acc(1'b0, 1'b1, 32'h10, 4'hF, 32'h0000_0003, 32'h0);
        @(negedge clk);
        check("irq_cleared_int", 32'(interrupt), 32'd0);
        acc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 32'h0);

        // ---------------- reset in the ACK cycle ----------------
        acc(1'b0, 1'b1, 32'h08, 4'hF, 32'h1234_5678, 32'h0);
        acc(1'b0, 1'b1, 32'h04, 4'hF, 32'h0000_0077, 32'h0);
        check("pre_rst_ctrl", ctrl_out, 32'h1234_5678);
        @(negedge clk);
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        check("pre_rst_interrupt", 32'(interrupt), 32'd1);
        @(negedge clk);
        bus.avalon_read = 1'b1;
        bus.address     = 32'h04;
        @(negedge clk);
        check("mid_ack", 32'(bus.acknowledge), 32'd1);
        check("mid_read_data", bus.read_data, 32'h0000_0077);
        #1 nreset = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.acknowledge), 32'd0);
        check("mid_rst_ctrl", ctrl_out, 32'h0);
        check("mid_rst_read_data", bus.read_data, 32'h0);
        check("mid_rst_interrupt", 32'(interrupt), 32'd0);
        bus.avalon_read = 1'b0;
        last_read       = 32'h0;
        @(negedge clk);
        nreset = 1'b1;
        acc(1'b1, 1'b0, 32'h04, 4'hF, 32'h0, 32'h0);
        acc(1'b1, 1'b0, 32'h14, 4'hF, 32'h0, 32'h0);
        acc(1'b1, 1'b0, 32'h00, 4'hF, 32'h0, ID);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
